// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Purpose:
//   Round-robin arbiter for a shared 4:1 mux. Each requester holds a level
//   request. The arbiter grants one owner at a time and drives the registered
//   mux select. Each handover passes through RELEASE and IDLE, so gnt is low
//   for at least two cycles while the mux switches over.
//
//   Optional feature macro: ARB_QUANTUM_EN
//     defined   -> a hold counter limits a grant to HOLD_MAX consecutive
//                  cycles. A forced revoke pulses expired for one cycle.
//     undefined -> a grant is held until the owner drops its request.
//                  expired is tied low and HOLD_MAX is not used.
//
// Parameters:
//   HOLD_MAX   maximum consecutive grant cycles per owner (1..256)
//
// Ports:
//   clk        input   1  rising-edge clock
//   rst        input   1  asynchronous, active-high reset
//   req        input   4  level requests, one bit per requester
//   gnt        output  4  registered one-hot (or zero) grant
//   select     output  2  registered mux select (current or last owner)
//   busy       output  1  high exactly while gnt is non-zero
//   expired    output  1  one-cycle pulse when a grant is revoked by quantum
//   dbg_state  output  2  FSM state (0 IDLE, 1 GRANT, 2 RELEASE) for checkers
//
// Handshake: req is a plain level request with no ready. A requester owns the
// mux from the first cycle gnt[i] is high until the cycle after it lowers
// req[i] or the quantum expires. While gnt is low, select keeps its last value.
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       busy,
  output logic       expired,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Legal range of the quantum. Out-of-range values elaborate to an empty,
  // clearly named block so they are easy to spot in a hierarchy dump.
  localparam bit HOLD_MAX_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 256);
  if (!HOLD_MAX_OK) begin : g_hold_max_out_of_range
  end

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       expired_q, expired_d;

  logic [1:0] win_idx;
  logic       owner_req;

`ifdef ARB_QUANTUM_EN
  // The counter spans 0..HOLD_MAX-1. Eight bits cover the full legal range.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       quantum_hit;
  assign quantum_hit = (cnt_q == HOLD_LAST);
`else
  logic       quantum_hit;
  assign quantum_hit = 1'b0;
`endif

  // First set request searching upward (mod 4) from the round-robin pointer.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_idx = 2'd0;
    found   = 1'b0;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win_idx = idx;
        found   = 1'b1;
      end
    end
  end

  // Only the owner's request line matters during GRANT.
  assign owner_req = req[sel_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    expired_d = 1'b0;
`ifdef ARB_QUANTUM_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          ptr_d   = win_idx + 2'd1;
`ifdef ARB_QUANTUM_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_QUANTUM_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // A voluntary drop takes precedence over expiry in the same cycle.
        if (!owner_req) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
        end else if (quantum_hit) begin
          state_d   = RELEASE;
          gnt_d     = 4'b0000;
          expired_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      expired_q <= expired_d;
    end
  end

`ifdef ARB_QUANTUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign select    = sel_q;
  assign busy      = |gnt_q;
  assign expired   = expired_q;
  assign dbg_state = state_q;

endmodule
